glitch_cmd_ctrl: RTL

Command controller between the host UART receiver and the glitch datapath. Parses framed host bytes (sync 0x00, command byte, optional payload) into register writes, target-UART forwards and glitch fire requests. Sequences the glitch: programmable delay, then an 8-slot pattern with programmable slot width. Optionally acknowledges each completed command over the host UART transmitter.

---
 rtl/glitch_cmd_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/glitch_cmd_ctrl.sv
// glitch_cmd_ctrl: host command parser and glitch sequencer.
// Frames are 0x00 sync, a command byte, then an optional argument byte.
// Commands write the pattern/delay/width registers, forward a byte to the
// target UART, fire the glitch, or soft-reset the registers.
// The sequencer waits `delay` cycles, then plays 8 slots of (width+1)
// cycles each, driving glitch_out = pattern[slot], LSB first.
// Optional build macro GLITCH_CMD_ACK_EN: acknowledge every command over
// the host UART (command byte on success, 0xEE on error/reject).
module glitch_cmd_ctrl #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tgt_data,
  output logic       tgt_en,
  input  logic       tgt_rdy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_rdy,
  output logic       glitch_out,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {P_IDLE, P_CMD, P_ARG, P_FWD} pstate_t;
  typedef enum logic [1:0] {S_OFF, S_DELAY, S_SLOT} sstate_t;

  pstate_t            pstate;
  sstate_t            sstate;
  logic [7:0]         cmd_q;
  logic [7:0]         fwd_q;
  logic [7:0]         pattern_q;
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] dly_cnt;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] wid_cnt;
  logic [2:0]         slot_idx;

  logic cmd_byte, arg_byte, fwd_drop, fwd_send;
  logic do_soft_rst, do_fire, fire_rej, bad_cmd, wr_ok, wr_rej, err_hit;

  // Byte decode shared by the parser, the sequencer and the ack logic
  always_comb begin
    cmd_byte    = rx_valid && (pstate == P_CMD);
    arg_byte    = rx_valid && (pstate == P_ARG);
    fwd_drop    = rx_valid && (pstate == P_FWD);
    fwd_send    = tgt_rdy  && (pstate == P_FWD);
    do_soft_rst = cmd_byte && (rx_data == 8'hFF);
    do_fire     = cmd_byte && (rx_data == 8'h30) && !busy;
    fire_rej    = cmd_byte && (rx_data == 8'h30) && busy;
    bad_cmd     = cmd_byte && !(rx_data inside {8'h00, 8'hFF, 8'h30, 8'h10,
                                                8'h11, 8'h20, 8'h21, 8'h22});
    // Register writes are frozen while a sequence runs; forwards are not
    wr_ok       = arg_byte && (cmd_q != 8'h10) && !busy;
    wr_rej      = arg_byte && (cmd_q != 8'h10) && busy;
    err_hit     = fire_rej || bad_cmd || wr_rej || fwd_drop;
  end

  // Parser FSM: framing, register writes, target forward, error strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate    <= P_IDLE;
      cmd_q     <= 8'h00;
      fwd_q     <= 8'h00;
      pattern_q <= 8'h00;
      delay_q   <= '0;
      width_q   <= '0;
      tgt_data  <= 8'h00;
      tgt_en    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err    <= err_hit;
      tgt_en <= 1'b0;
      case (pstate)
        P_IDLE: if (rx_valid && rx_data == 8'h00) pstate <= P_CMD;
        P_CMD: if (rx_valid) begin
          cmd_q <= rx_data;
          case (rx_data)
            8'h00: pstate <= P_CMD;
            8'hFF: begin
              pattern_q <= 8'h00;
              delay_q   <= '0;
              width_q   <= '0;
              pstate    <= P_IDLE;
            end
            8'h10, 8'h11, 8'h20, 8'h21, 8'h22: pstate <= P_ARG;
            default: pstate <= P_IDLE;
          endcase
        end
        P_ARG: if (rx_valid) begin
          if (cmd_q == 8'h10) begin
            fwd_q  <= rx_data;
            pstate <= P_FWD;
          end else begin
            pstate <= P_IDLE;
            if (wr_ok) begin
              case (cmd_q)
                8'h11: pattern_q <= rx_data;
                8'h20: delay_q <= (delay_q & ~DELAY_W'(16'h00FF)) | DELAY_W'(rx_data);
                8'h21: delay_q <= (delay_q & ~DELAY_W'(16'hFF00)) | DELAY_W'({rx_data, 8'h00});
                8'h22: width_q <= WIDTH_W'(rx_data);
                default: ;
              endcase
            end
          end
        end
        P_FWD: if (fwd_send) begin
          tgt_en   <= 1'b1;
          tgt_data <= fwd_q;
          pstate   <= P_IDLE;
        end
        default: pstate <= P_IDLE;
      endcase
    end
  end

  // Glitch sequencer: delay countdown, then 8 slots of width+1 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sstate     <= S_OFF;
      dly_cnt    <= '0;
      wid_cnt    <= '0;
      slot_idx   <= 3'd0;
      busy       <= 1'b0;
      glitch_out <= 1'b0;
    end else if (do_soft_rst) begin
      sstate     <= S_OFF;
      busy       <= 1'b0;
      glitch_out <= 1'b0;
    end else begin
      case (sstate)
        S_OFF: if (do_fire) begin
          busy     <= 1'b1;
          slot_idx <= 3'd0;
          wid_cnt  <= width_q;
          // Zero delay goes straight to slot 0 on the cycle after the fire
          if (delay_q == '0) begin
            sstate     <= S_SLOT;
            glitch_out <= pattern_q[0];
          end else begin
            sstate  <= S_DELAY;
            dly_cnt <= delay_q;
          end
        end
        S_DELAY: begin
          if (dly_cnt == DELAY_W'(1)) begin
            sstate     <= S_SLOT;
            glitch_out <= pattern_q[0];
          end else begin
            dly_cnt <= dly_cnt - DELAY_W'(1);
          end
        end
        S_SLOT: begin
          if (wid_cnt == '0) begin
            if (slot_idx == 3'd7) begin
              sstate     <= S_OFF;
              busy       <= 1'b0;
              glitch_out <= 1'b0;
            end else begin
              slot_idx   <= slot_idx + 3'd1;
              glitch_out <= pattern_q[slot_idx + 3'd1];
              wid_cnt    <= width_q;
            end
          end else begin
            wid_cnt <= wid_cnt - WIDTH_W'(1);
          end
        end
        default: sstate <= S_OFF;
      endcase
    end
  end

`ifdef GLITCH_CMD_ACK_EN
  logic       ack_ev;
  logic       ack_pend;
  logic [7:0] ack_val;
  logic [7:0] ack_buf;

  // Ack source select; an error outranks a forward completing the same cycle
  always_comb begin
    ack_ev  = 1'b0;
    ack_val = 8'h00;
    if (do_soft_rst || do_fire) begin
      ack_ev  = 1'b1;
      ack_val = rx_data;
    end else if (wr_ok) begin
      ack_ev  = 1'b1;
      ack_val = cmd_q;
    end else if (fwd_send) begin
      ack_ev  = 1'b1;
      ack_val = 8'h10;
    end
    if (err_hit) begin
      ack_ev  = 1'b1;
      ack_val = 8'hEE;
    end
  end

  // One-entry ack buffer; a newer ack replaces a pending one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pend <= 1'b0;
      ack_buf  <= 8'h00;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_en <= 1'b0;
      // Skip the cycle right after a send so tx_en never stretches
      if (ack_pend && tx_rdy && !tx_en) begin
        tx_en    <= 1'b1;
        tx_data  <= ack_buf;
        ack_pend <= 1'b0;
      end
      if (ack_ev) begin
        ack_pend <= 1'b1;
        ack_buf  <= ack_val;
      end
    end
  end
`else
  assign tx_en   = 1'b0;
  assign tx_data = 8'h00;
  logic unused_tx_rdy;
  assign unused_tx_rdy = tx_rdy;
`endif

endmodule
